piso_serial_tx: RTL and testbench
=================================

PISO_SERIAL_TX -- requirements
Module: piso_serial_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 serialized first; 0 = bit 0 first.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port din  input  WIDTH  parallel word to serialize; sampled only on an accept edge.
REQ-006 Port din_valid  input  1  din holds a word offered for transmission.
REQ-007 Port din_ready  output  1  block can accept a word this cycle.
REQ-008 Port dout  output  1  serial data bit, registered.
REQ-009 Port dout_en  output  1  dout carries a valid data bit this cycle, registered.
REQ-010 Port dout_last  output  1  current dout bit is the final bit of its word, registered.
REQ-011 Port busy  output  1  a word is being shifted out (state SHIFT).

Function
REQ-012 The block SHALL implement a two-state FSM, IDLE and SHIFT, plus a WIDTH-bit shift register and a bit counter of clog2(WIDTH) bits.
REQ-013 An accept SHALL occur on any rising edge where din_valid=1 and din_ready=1; no other condition loads din.
REQ-014 din_ready SHALL be 1 in IDLE, 1 in SHIFT only when the counter equals WIDTH-1, and 0 otherwise (combinational from state and counter).
REQ-015 On an accept in IDLE, the FSM SHALL move to SHIFT, load the shift register from din, and clear the counter to 0.
REQ-016 Latency: with the accept at edge k, the first bit SHALL appear on dout with dout_en=1 in the cycle after edge k; bit i SHALL appear in cycle k+1+i, for i = 0..WIDTH-1.
REQ-017 Bit order SHALL follow MSB_FIRST: din[WIDTH-1-i] when 1, din[i] when 0.
REQ-018 In SHIFT the block SHALL advance one bit per clock and increment the counter; dout_last SHALL be 1 exactly while the counter equals WIDTH-1.
REQ-019 On the edge ending the last bit, the FSM SHALL go to IDLE if there is no accept, or stay in SHIFT (counter = 0, new word loaded) if there is one; back-to-back words therefore SHALL have no idle gap.
REQ-020 When dout_en=0, dout and dout_last SHALL be 0.
REQ-021 din_valid while din_ready=0 SHALL be ignored and SHALL NOT disturb the word in flight; the source holds din and din_valid until accepted.
REQ-022 busy SHALL equal (state == SHIFT); dout_en SHALL equal busy.

Reset
REQ-023 While rst=1 at a rising edge, the FSM SHALL go to IDLE and the counter and shift register SHALL be cleared; rst SHALL take priority over an accept on the same edge.
REQ-024 After reset: din_ready=1, dout=0, dout_en=0, dout_last=0, busy=0.
REQ-025 Reset asserted mid-word SHALL abandon the word with no further dout_en pulses; the next word SHALL start cleanly from bit 0.

Verification (WIDTH=8 unless stated)
REQ-026 MSB_FIRST=1, single accept of 8'hA5 -> dout 1,0,1,0,0,1,0,1 on 8 consecutive dout_en cycles; dout_last on the 8th cycle only; then IDLE with din_ready=1.
REQ-027 MSB_FIRST=0, accept of 8'h01 -> dout 1,0,0,0,0,0,0,0; accept of 8'h80 -> 0,0,0,0,0,0,0,1.
REQ-028 Back-to-back: 8'hF0 then 8'h0F, the second offered during the first word's last bit -> 16 contiguous dout_en cycles, MSB-first bits 11110000 00001111, dout_last on cycles 8 and 16.
REQ-029 din_valid=1 with din=8'h3C asserted in cycle 3 of word 8'hFF -> word 8'hFF completes intact; 8'h3C accepted only at the last-bit edge and serialized next.
REQ-030 rst pulsed during bit 4 of 8'hAA -> next cycle dout_en=0, busy=0, din_ready=1; a following accept of 8'h55 serializes 0,1,0,1,0,1,0,1.
REQ-031 rst=1 on the same edge as din_valid=1 -> no accept; block stays in IDLE with all outputs at reset values.

Source files
------------

// File: rtl/piso_serial_tx.sv
// piso_serial_tx: parallel-in / serial-out transmitter.
// A word accepted on din is shifted out one bit per clock on dout, framed by
// dout_en and dout_last. A new word can be accepted during the last bit of the
// current one, so consecutive words stream out with no idle gap.

module piso_serial_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_en,
    output logic             dout_last,
    output logic             busy
);

    localparam int            CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_countNext;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shiftNext;
    logic             r_last;
    logic             w_lastNext;
    logic             w_atLast;
    logic             w_accept;

    // The counter sits at zero while idle, so the last-bit compare only matters in SHIFT.
    assign w_atLast  = (r_count == LAST_COUNT);
    assign din_ready = (r_state == IDLE) || w_atLast;
    assign w_accept  = din_valid && din_ready;

    // State register: reset wins over any accept offered on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic: stay in SHIFT across a last-bit accept to avoid a gap.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_stateNext = SHIFT;
                end
            end
            SHIFT: begin
                if (w_atLast && !w_accept) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Datapath next values: load on accept, otherwise shift zeros in while in SHIFT
    // so the register is empty (dout low) by the time the word is finished.
    always_comb begin
        w_countNext = r_count;
        w_shiftNext = r_shift;
        if (w_accept) begin
            w_countNext = '0;
            w_shiftNext = din;
        end else if (r_state == SHIFT) begin
            w_countNext = w_atLast ? '0 : (r_count + CW'(1));
            if (MSB_FIRST) begin
                w_shiftNext = {r_shift[WIDTH-2:0], 1'b0};
            end else begin
                w_shiftNext = {1'b0, r_shift[WIDTH-1:1]};
            end
        end
        w_lastNext = (w_stateNext == SHIFT) && (w_countNext == LAST_COUNT);
    end

    // Datapath registers, including the registered last-bit flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_shift <= '0;
            r_last  <= 1'b0;
        end else begin
            r_count <= w_countNext;
            r_shift <= w_shiftNext;
            r_last  <= w_lastNext;
        end
    end

    assign busy      = (r_state == SHIFT);
    assign dout_en   = busy;
    assign dout_last = r_last;
    assign dout      = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];

endmodule

// File: tb/tb_piso_serial_tx.sv
// tb_piso_serial_tx: drives an MSB-first and an LSB-first instance with the same
// stimulus and compares both against a queue-of-pending-bits reference model.

module tb_piso_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;

    logic readyM, doutM, enM, lastM, busyM;
    logic readyL, doutL, enL, lastL, busyL;

    int passCount  = 0;
    int checkCount = 0;

    // Reference model: bits still to appear on dout, head = bit currently shown.
    logic qM[$];
    logic qL[$];
    logic lastAccept;

    // Observed serial streams, shifted in as they appear (first bit ends up highest).
    logic [15:0] seqM, seqL, lastMaskM;
    int          enCount;

    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dutMsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(readyM), .dout(doutM), .dout_en(enM),
        .dout_last(lastM), .busy(busyM)
    );

    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dutLsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(readyL), .dout(doutL), .dout_en(enL),
        .dout_last(lastL), .busy(busyL)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic logic [4:0] expVec(input int sz, input logic head);
        // {busy, din_ready, dout_en, dout, dout_last}
        return {sz > 0, sz <= 1, sz > 0, (sz > 0) ? head : 1'b0, sz == 1};
    endfunction

    function automatic logic [9:0] expBoth();
        logic hM, hL;
        hM = (qM.size() > 0) ? qM[0] : 1'b0;
        hL = (qL.size() > 0) ? qL[0] : 1'b0;
        return {expVec(qM.size(), hM), expVec(qL.size(), hL)};
    endfunction

    function automatic logic [9:0] obsBoth();
        return {busyM, readyM, enM, doutM, lastM, busyL, readyL, enL, doutL, lastL};
    endfunction

    function automatic void clearSeq();
        seqM      = '0;
        seqL      = '0;
        lastMaskM = '0;
        enCount   = 0;
    endfunction

    // Drive one cycle of inputs (called just after a falling edge), advance the
    // model across the rising edge, and return at the next falling edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d);
        logic acc;
        rst       = r;
        din_valid = v;
        din       = d;
        acc       = v && !r && (qM.size() <= 1);
        @(posedge clk);
        if (r) begin
            qM.delete();
            qL.delete();
        end else begin
            if (qM.size() > 0) void'(qM.pop_front());
            if (qL.size() > 0) void'(qL.pop_front());
            if (acc) begin
                for (int i = 0; i < 8; i++) begin
                    qM.push_back(d[7-i]);
                    qL.push_back(d[i]);
                end
            end
        end
        lastAccept = acc;
        @(negedge clk);
        if (enM) begin
            seqM      = {seqM[14:0], doutM};
            lastMaskM = {lastMaskM[14:0], lastM};
            enCount++;
        end
        if (enL) begin
            seqL = {seqL[14:0], doutL};
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 8'h00);
            checkCount++;
            if (obsBoth() !== 10'b01000_01000) begin
                $display("[TB] FAIL reset_state: got %b expected %b", obsBoth(), 10'b01000_01000);
            end else passCount++;
        end
    endtask

    task automatic test_msb_single();
        clearSeq();
        applyStimulus(1'b0, 1'b1, 8'hA5);
        for (int i = 0; i < 9; i++) begin
            checkCount++;
            if (obsBoth() !== expBoth()) begin
                $display("[TB] FAIL single_cycle%0d: got %b expected %b", i, obsBoth(), expBoth());
            end else passCount++;
            applyStimulus(1'b0, 1'b0, 8'h00);
        end
        checkCount++;
        if ({seqM[7:0], lastMaskM, enCount} !== {8'hA5, 16'h0001, 32'd8}) begin
            $display("[TB] FAIL single_A5 bits/last/count: got %h/%h/%0d expected a5/0001/8",
                     seqM[7:0], lastMaskM, enCount);
        end else passCount++;
        checkCount++;
        if (obsBoth() !== 10'b01000_01000) begin
            $display("[TB] FAIL single_idle_after: got %b expected %b", obsBoth(), 10'b01000_01000);
        end else passCount++;
    endtask

    task automatic test_lsb_order();
        logic [7:0] words[2];
        logic [7:0] streams[2];
        words   = '{8'h01, 8'h80};
        streams = '{8'h80, 8'h01};
        for (int w = 0; w < 2; w++) begin
            clearSeq();
            applyStimulus(1'b0, 1'b1, words[w]);
            for (int i = 0; i < 8; i++) begin
                checkCount++;
                if (obsBoth() !== expBoth()) begin
                    $display("[TB] FAIL lsb_word%0d_cycle%0d: got %b expected %b", w, i, obsBoth(), expBoth());
                end else passCount++;
                applyStimulus(1'b0, 1'b0, 8'h00);
            end
            checkCount++;
            if (seqL[7:0] !== streams[w]) begin
                $display("[TB] FAIL lsb_stream_%h: got %b expected %b", words[w], seqL[7:0], streams[w]);
            end else passCount++;
        end
    endtask

    task automatic test_back_to_back();
        clearSeq();
        applyStimulus(1'b0, 1'b1, 8'hF0);
        for (int i = 0; i < 16; i++) begin
            checkCount++;
            if (obsBoth() !== expBoth()) begin
                $display("[TB] FAIL b2b_cycle%0d: got %b expected %b", i, obsBoth(), expBoth());
            end else passCount++;
            applyStimulus(1'b0, (i == 7), (i == 7) ? 8'h0F : 8'h00);
        end
        checkCount++;
        if ({seqM, seqL, lastMaskM, enCount} !== {16'hF00F, 16'h0FF0, 16'h0101, 32'd16}) begin
            $display("[TB] FAIL b2b_stream msb/lsb/last/count: got %h/%h/%h/%0d expected f00f/0ff0/0101/16",
                     seqM, seqL, lastMaskM, enCount);
        end else passCount++;
    endtask

    task automatic test_hold_while_busy();
        int holdSteps;
        clearSeq();
        applyStimulus(1'b0, 1'b1, 8'hFF);
        applyStimulus(1'b0, 1'b0, 8'h00);
        holdSteps = 0;
        do begin
            applyStimulus(1'b0, 1'b1, 8'h3C);
            holdSteps++;
            checkCount++;
            if (obsBoth() !== expBoth()) begin
                $display("[TB] FAIL hold_step%0d: got %b expected %b", holdSteps, obsBoth(), expBoth());
            end else passCount++;
        end while (!lastAccept && holdSteps < 20);
        if (!lastAccept) begin
            checkCount++;
            $display("[TB] FAIL hold_accept_timeout: got no accept expected accept within 20 cycles");
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            checkCount++;
            if (obsBoth() !== expBoth()) begin
                $display("[TB] FAIL hold_tail%0d: got %b expected %b", i, obsBoth(), expBoth());
            end else passCount++;
        end
        checkCount++;
        if ({seqM, enCount} !== {16'hFF3C, 32'd16}) begin
            $display("[TB] FAIL hold_stream: got %h/%0d expected ff3c/16", seqM, enCount);
        end else passCount++;
    endtask

    task automatic test_reset_midword();
        clearSeq();
        applyStimulus(1'b0, 1'b1, 8'hAA);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkCount++;
        if (obsBoth() !== 10'b01000_01000) begin
            $display("[TB] FAIL midword_reset_state: got %b expected %b", obsBoth(), 10'b01000_01000);
        end else passCount++;
        clearSeq();
        applyStimulus(1'b0, 1'b1, 8'h55);
        for (int i = 0; i < 8; i++) begin
            checkCount++;
            if (obsBoth() !== expBoth()) begin
                $display("[TB] FAIL midword_next_cycle%0d: got %b expected %b", i, obsBoth(), expBoth());
            end else passCount++;
            applyStimulus(1'b0, 1'b0, 8'h00);
        end
        checkCount++;
        if ({seqM[7:0], seqL[7:0], enCount} !== {8'h55, 8'hAA, 32'd8}) begin
            $display("[TB] FAIL midword_next_stream: got %h/%h/%0d expected 55/aa/8",
                     seqM[7:0], seqL[7:0], enCount);
        end else passCount++;
    endtask

    task automatic test_reset_with_valid();
        applyStimulus(1'b1, 1'b1, 8'hA5);
        checkCount++;
        if (obsBoth() !== 10'b01000_01000) begin
            $display("[TB] FAIL reset_vs_accept: got %b expected %b", obsBoth(), 10'b01000_01000);
        end else passCount++;
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkCount++;
        if (obsBoth() !== 10'b01000_01000) begin
            $display("[TB] FAIL reset_vs_accept_after: got %b expected %b", obsBoth(), 10'b01000_01000);
        end else passCount++;
    endtask

    task automatic test_random();
        logic       r, v;
        logic [7:0] d;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 40) == 0);
            v = $urandom_range(0, 1);
            d = 8'($urandom);
            applyStimulus(r, v, d);
            checkCount++;
            if (obsBoth() !== expBoth()) begin
                $display("[TB] FAIL random_cycle%0d: got %b expected %b", i, obsBoth(), expBoth());
            end else passCount++;
        end
    endtask

    // Test sequence.
    initial begin
        rst       = 1'b1;
        din_valid = 1'b0;
        din       = 8'h00;
        clearSeq();
        test_reset();
        test_msb_single();
        test_lsb_order();
        test_back_to_back();
        test_hold_while_busy();
        test_reset_midword();
        test_reset_with_valid();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
